// File: rtl/shift_right_sequential.sv
// shift_right_sequential
//
// Multi-cycle 24-bit right shifter for the execute stage. It moves one bit
// position per clock and sits behind a start/done handshake. The shift amount
// is B + SHAMT. Amounts of 24 or more saturate to a full 24-bit shift. An
// amount of zero still takes one cycle and returns A unchanged.
//
// Ports:
//   Clock   in   1  rising-edge clock
//   Reset   in   1  synchronous active-high reset, overrides everything
//   Start   in   1  request a shift (only honoured while idle)
//   Arith   in   1  1 = sign fill, 0 = zero fill (captured with Start)
//   A       in  24  operand to shift (captured with Start)
//   B       in  24  register part of the shift amount (captured with Start)
//   SHAMT   in   4  immediate part of the shift amount (captured with Start)
//   Busy    out  1  high while a shift is in progress
//   Done    out  1  one-cycle pulse in the cycle Result is first valid
//   Result  out 24  registered shift result, held until the next completion

module shift_right_sequential (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Arith,
  input  logic [23:0] A,
  input  logic [23:0] B,
  input  logic [3:0]  SHAMT,
  output logic        Busy,
  output logic        Done,
  output logic [23:0] Result
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] work, work_nxt;
  logic [23:0] result_nxt;
  logic [4:0]  count, count_nxt;
  logic        fill, fill_nxt;
  logic        hold, hold_nxt;
  logic        done_nxt;
  logic [24:0] sum;

  // The amount is summed at 25 bits so that a huge B cannot wrap around to a
  // small shift.
  assign sum = {1'b0, B} + {21'd0, SHAMT};

  // Busy is decoded from the state register alone, so it has no
  // combinational path from any input.
  assign Busy = (state == SHIFT);

  // Next-state logic. IDLE captures the operands. SHIFT moves one bit per
  // cycle and publishes the result on the step where the counter expires.
  // The hold flag marks a zero-amount request: that request spends its single
  // step without shifting, which keeps the latency at a minimum of one cycle.
  always_comb begin
    state_nxt  = state;
    work_nxt   = work;
    result_nxt = Result;
    count_nxt  = count;
    fill_nxt   = fill;
    hold_nxt   = hold;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          work_nxt  = A;
          fill_nxt  = Arith & A[23];
          state_nxt = SHIFT;
          if (sum == 25'd0) begin
            count_nxt = 5'd1;
            hold_nxt  = 1'b1;
          end else if (sum >= 25'd24) begin
            count_nxt = 5'd24;
            hold_nxt  = 1'b0;
          end else begin
            count_nxt = sum[4:0];
            hold_nxt  = 1'b0;
          end
        end
      end
      SHIFT: begin
        work_nxt  = hold ? work : {fill, work[23:1]};
        count_nxt = count - 5'd1;
        if (count == 5'd1) begin
          result_nxt = work_nxt;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register. Reset aborts any operation in flight and clears the
  // result. It also outranks a simultaneous Start.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      work   <= 24'd0;
      Result <= 24'd0;
      count  <= 5'd0;
      fill   <= 1'b0;
      hold   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      work   <= work_nxt;
      Result <= result_nxt;
      count  <= count_nxt;
      fill   <= fill_nxt;
      hold   <= hold_nxt;
      Done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shift_right_sequential.sv
// tb_shift_right_sequential
//
// Directed bench for shift_right_sequential. Inputs change on the falling
// edge and outputs are sampled there too, well away from the rising edge.
// Every expected value below is hand-computed from the shifter's behaviour.

module tb_shift_right_sequential;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic        Arith;
  logic [23:0] A;
  logic [23:0] B;
  logic [3:0]  SHAMT;
  logic        Busy;
  logic        Done;
  logic [23:0] Result;

  int total = 0;
  int bad   = 0;

  shift_right_sequential dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .Arith  (Arith),
    .A      (A),
    .B      (B),
    .SHAMT  (SHAMT),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  // Free-running 10 ns clock.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Compare one observed value against its expected value and count the
  // outcome.
  task automatic checkOutput(input string tag, input logic [23:0] obs,
                             input logic [23:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one operation from a falling edge, then walk the L busy cycles.
  // On each busy cycle the bench checks Busy/Done and that Result still holds
  // the previous value. If pulseAt >= 0, a stray Start with different operands
  // is pulsed on that busy cycle and must be ignored. The task ends on the
  // falling edge of the Done cycle, after the final result is checked.
  task automatic applyStimulus(input string tag, input logic [23:0] a,
                               input logic [23:0] b, input logic [3:0] sh,
                               input logic ar, input int lat,
                               input logic [23:0] exp, input logic [23:0] prev,
                               input int pulseAt);
    A = a; B = b; SHAMT = sh; Arith = ar; Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    A = 24'h5A5A5A; B = 24'd0; SHAMT = 4'd0; Arith = ~ar;
    for (int j = 0; j < lat; j++) begin
      checkOutput({tag, "_busy"}, {22'd0, Busy, Done}, 24'd2);
      checkOutput({tag, "_hold"}, Result, prev);
      if (j == pulseAt) Start = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      Start = 1'b0;
    end
    checkOutput({tag, "_done"}, {22'd0, Busy, Done}, 24'd1);
    checkOutput({tag, "_result"}, Result, exp);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b1; Arith = 1'b1;
    A = 24'hFFFFFF; B = 24'd3; SHAMT = 4'd1;
    $display("[TB] reset held with Start high");
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      checkOutput("reset_result", Result, 24'h000000);
      checkOutput("reset_flags", {22'd0, Busy, Done}, 24'd0);
    end
    Reset = 1'b0; Start = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("post_reset_idle", {22'd0, Busy, Done}, 24'd0);

    $display("[TB] logical and arithmetic shifts");
    applyStimulus("logical4", 24'hF0F0F0, 24'd2, 4'd2, 1'b0, 4,
                  24'h0F0F0F, 24'h000000, -1);
    applyStimulus("arith4", 24'h800001, 24'd0, 4'd4, 1'b1, 4,
                  24'hF80000, 24'h0F0F0F, -1);
    applyStimulus("logic4b", 24'h800001, 24'd0, 4'd4, 1'b0, 4,
                  24'h080000, 24'hF80000, -1);

    $display("[TB] saturating amounts");
    applyStimulus("sat_arith", 24'h9ABCDE, 24'hFFFFFF, 4'd15, 1'b1, 24,
                  24'hFFFFFF, 24'h080000, -1);
    applyStimulus("sat_logic", 24'h9ABCDE, 24'hFFFFFF, 4'd15, 1'b0, 24,
                  24'h000000, 24'hFFFFFF, -1);

    $display("[TB] zero amount then back-to-back with stray start");
    applyStimulus("zero_amt", 24'h123456, 24'd0, 4'd0, 1'b1, 1,
                  24'h123456, 24'h000000, -1);
    applyStimulus("b2b_arith3", 24'hABCDEF, 24'd3, 4'd0, 1'b1, 3,
                  24'hF579BD, 24'h123456, 1);
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("done_single_pulse", {22'd0, Busy, Done}, 24'd0);
    checkOutput("result_stable_idle", Result, 24'hF579BD);

    $display("[TB] reset in the middle of a 20-cycle shift");
    A = 24'hFEDCBA; B = 24'd16; SHAMT = 4'd4; Arith = 1'b0; Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      checkOutput("midrst_busy", {22'd0, Busy, Done}, 24'd2);
      @(posedge Clock);
      @(negedge Clock);
    end
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    checkOutput("midrst_flags", {22'd0, Busy, Done}, 24'd0);
    checkOutput("midrst_result", Result, 24'h000000);
    for (int j = 0; j < 12; j++) begin
      @(posedge Clock);
      @(negedge Clock);
      checkOutput("midrst_no_done", {22'd0, Busy, Done}, 24'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_right_sequential.md
# shift_right_sequential

Multi-cycle 24-bit right shifter for the CPU execute stage, the counterpart of the combinational left-shift path. The shift amount is the sum of the zero-extended 4-bit `SHAMT` field and register operand `B`, matching the left shifter's amount rule. The block performs logical or arithmetic right shifts one bit per cycle, behind a start/done handshake. The ALU control sequencer stalls on `Busy` and picks up `Result` on `Done`.

## Interface

Parameters:
- None. Width is fixed at 24 bits, matching the datapath.

Ports (clock and reset first):
- `Clock` input 1: the single clock; all state changes on its rising edge.
- `Reset` input 1: synchronous, active-high reset; overrides every other input.
- `Start` input 1: request a shift; sampled only while idle.
- `Arith` input 1: 1 = arithmetic (sign fill), 0 = logical (zero fill); sampled with `Start`.
- `A` input 24: operand to be shifted; sampled with `Start`.
- `B` input 24: register part of the shift amount; sampled with `Start`.
- `SHAMT` input 4: immediate part of the shift amount; sampled with `Start`.
- `Busy` output 1: high while a shift is in progress.
- `Done` output 1: one-cycle pulse when `Result` is updated.
- `Result` output 24: registered shifted value.

## Operation

States:
- **IDLE**
  - `Busy` = 0.
  - `Start` = 1 captures the inputs and moves to SHIFT.
  - Otherwise stays in IDLE.
- **SHIFT**
  - `Busy` = 1.
  - Each cycle: working register W ← {fill, W[23:1]}, and counter N ← N − 1.
  - When N reaches 0, `Result` ← W, `Done` is pulsed, and the state returns to IDLE.

Capture on an accepted `Start`:
- W ← `A`.
- Fill bit ← `Arith` ? `A[23]` : 0.
- Sum S = `B` + {20'd0, `SHAMT`}, computed at 25 bits so there is no wrap-around.
- N ← (S ≥ 24) ? 24 : S[4:0].
  - S ≥ 24 therefore yields all-fill: 24'h000000 for logical, or 24 copies of `A[23]` for arithmetic.
- If S = 0, N is forced to 1 and the fill is ignored for that one step, so `Result` = `A` unchanged. Latency stays uniform at a minimum of one cycle.

Handshake rules:
- `Start` while `Busy` = 1 is ignored. The in-flight operation is not disturbed and nothing is queued.
- `Done` is asserted in the first cycle back in IDLE. A `Start` in that same cycle is accepted, allowing back-to-back operations.
- `Result` is stable from the `Done` pulse until the next operation completes. It does not change during SHIFT.
- Inputs `A`, `B`, `SHAMT` and `Arith` may change freely after capture.

Reset:
- `Reset` = 1 on any edge forces IDLE, `Busy` = 0, `Done` = 0, `Result` = 24'h000000, W = 0, N = 0.
- This applies mid-operation as well: the shift in progress is aborted and no `Done` is produced.
- `Start` asserted together with `Reset` is ignored.

## Timing

- `Start` sampled high at edge k (IDLE): `Busy` = 1 from edge k through edge k+L−1, where L = max(min(S,24),1).
- The final shift and the `Result` update occur at edge k+L. `Busy` = 0 and `Done` = 1 for the cycle following edge k+L.
- Worst case L = 24: 24 busy cycles, with `Done` 24 cycles after the start edge.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan

- **Reset:** hold `Reset` for 2 cycles with `Start` = 1 → `Result` = 0, `Busy` = 0, `Done` = 0 throughout; no operation starts.
- **Logical shift:** `A` = 24'hF0F0F0, `B` = 2, `SHAMT` = 2, `Arith` = 0 → `Busy` for 4 cycles, then `Done` pulse with `Result` = 24'h0F0F0F.
- **Arithmetic shift:** `A` = 24'h800001, `B` = 0, `SHAMT` = 4, `Arith` = 1 → `Result` = 24'hF80000 after L = 4.
  - Repeat with `Arith` = 0 → `Result` = 24'h080000.
- **Saturation:** `A` = 24'h9ABCDE, `B` = 24'hFFFFFF, `SHAMT` = 15 (25-bit sum) → L = 24.
  - `Arith` = 1 → `Result` = 24'hFFFFFF.
  - `Arith` = 0 → `Result` = 24'h000000.
- **Zero amount, then back-to-back:** `B` = 0, `SHAMT` = 0, `A` = 24'h123456 → `Done` one cycle after start with `Result` = 24'h123456.
  - A new `Start` in the `Done` cycle is accepted (`Busy` high on the next cycle).
  - A `Start` pulsed mid-shift is ignored.
- **Mid-operation reset:** start an L = 20 shift, assert `Reset` at busy cycle 10 → `Busy` low and `Result` = 0 on the next cycle; no `Done` pulse follows.
